// File: rtl/fetch_unit.sv
// fetch_unit: two-phase instruction fetch sequencer.
//
// Each instruction is two ROM bytes. In FETCH the first byte is captured into
// the fetch register ({instr, oprnd}) and pc steps forward. In EXEC the
// second byte is presented combinationally as program_byte, and decode may
// request a jump (load_pc) or a sequential step (inc_pc). The block only
// advances on cycles where enable=1 and rom_ready=1; otherwise all state holds.
//
// Ports:
//   clock        in   system clock, rising-edge
//   reset        in   synchronous active-high reset
//   enable       in   run/halt
//   rom_data     in   [7:0] ROM byte at address pc
//   rom_ready    in   rom_data valid this cycle
//   load_pc      in   jump request (EXEC only)
//   inc_pc       in   pc increment request (EXEC only)
//   pc           out  [11:0] program counter / ROM address
//   instr        out  [3:0] opcode nibble of fetch register
//   oprnd        out  [3:0] operand nibble of fetch register
//   program_byte out  [7:0] second instruction byte (= rom_data)
//   address_ram  out  [11:0] {oprnd, program_byte}
//   phase        out  0 in FETCH, 1 in EXEC
//   stall        out  enable & ~rom_ready
//   retire       out  one-cycle pulse after each EXEC advance
//   instr_count  out  [15:0] completed-instruction counter
module fetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rom_data,
    input  logic        rom_ready,
    input  logic        load_pc,
    input  logic        inc_pc,
    output logic [11:0] pc,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic [7:0]  program_byte,
    output logic [11:0] address_ram,
    output logic        phase,
    output logic        stall,
    output logic        retire,
    output logic [15:0] instr_count
);

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StExec  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  fetch_q, fetch_d;
    logic [15:0] count_q, count_d;
    logic        retire_q, retire_d;
    logic        advance;

    assign advance = enable & rom_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fetch_d  = fetch_q;
        count_d  = count_q;
        retire_d = 1'b0;
        if (advance) begin
            unique case (state_q)
                StFetch: begin
                    fetch_d = rom_data;
                    pc_d    = pc_q + 12'd1;
                    state_d = StExec;
                end
                StExec: begin
                    // Jump wins over increment when decode asserts both.
                    if (load_pc) begin
                        pc_d = {fetch_q[3:0], rom_data};
                    end else if (inc_pc) begin
                        pc_d = pc_q + 12'd1;
                    end
                    state_d  = StFetch;
                    retire_d = 1'b1;
                    count_d  = count_q + 16'd1;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= 12'h000;
            fetch_q  <= 8'h00;
            count_q  <= 16'h0000;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fetch_q  <= fetch_d;
            count_q  <= count_d;
            retire_q <= retire_d;
        end
    end

    assign pc           = pc_q;
    assign instr        = fetch_q[7:4];
    assign oprnd        = fetch_q[3:0];
    assign program_byte = rom_data;
    assign address_ram  = {fetch_q[3:0], rom_data};
    assign phase        = state_q;
    assign stall        = enable & ~rom_ready;
    assign retire       = retire_q;
    assign instr_count  = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run/halt; when 0, all state holds.
REQ-005 rom_data  input  8  program ROM output for the address on pc.
REQ-006 rom_ready  input  1  rom_data valid this cycle; when 0, the block stalls.
REQ-007 load_pc  input  1  jump request from decode; sampled in EXEC only.
REQ-008 inc_pc  input  1  PC increment enable from decode; sampled in EXEC only.
REQ-009 pc  output  12  program counter, drives the ROM address.
REQ-010 instr  output  4  fetch register high nibble (opcode).
REQ-011 oprnd  output  4  fetch register low nibble (operand).
REQ-012 program_byte  output  8  second instruction byte, combinationally equal to rom_data.
REQ-013 address_ram  output  12  {oprnd, program_byte}.
REQ-014 phase  output  1  0 in FETCH, 1 in EXEC; feeds decode address bit 6.
REQ-015 stall  output  1  enable & ~rom_ready, combinational.
REQ-016 retire  output  1  registered one-cycle pulse per completed instruction.
REQ-017 instr_count  output  16  completed-instruction counter.

Function
REQ-018 FSM SHALL have two states: FETCH and EXEC; phase SHALL equal the registered state bit.
REQ-019 The state SHALL advance only on cycles where enable=1 and rom_ready=1; otherwise pc, fetch register, state and instr_count SHALL hold.
REQ-020 FETCH advance: {instr,oprnd} <= rom_data; pc <= pc+1; state -> EXEC.
REQ-021 EXEC advance: if load_pc=1, pc <= {oprnd, rom_data}; else if inc_pc=1, pc <= pc+1; else pc holds; state -> FETCH.
REQ-022 load_pc SHALL take priority over inc_pc when both are 1.
REQ-023 load_pc and inc_pc SHALL be ignored in FETCH.
REQ-024 The fetch register SHALL load only on a FETCH advance.
REQ-025 pc increment SHALL be modulo 4096 (0xFFF+1 -> 0x000), with no flag generated.
REQ-026 retire SHALL be 1 in the cycle after each EXEC advance and 0 otherwise.
REQ-027 instr_count SHALL increment by 1 on each EXEC advance and SHALL wrap 0xFFFF -> 0x0000.
REQ-028 Under stall, outputs SHALL stay stable; a stalled EXEC SHALL re-sample load_pc/inc_pc on the cycle it finally advances.
REQ-029 enable falling mid-instruction SHALL freeze the block in its current state; the instruction SHALL resume from that state when enable returns to 1.

Reset
REQ-030 reset=1 on a rising edge SHALL set pc=0x000, instr=0, oprnd=0, state=FETCH (phase=0), retire=0, instr_count=0, regardless of enable, rom_ready or state.
REQ-031 reset SHALL have priority over every other input, including a mid-EXEC load_pc.
REQ-032 The first FETCH after reset release SHALL read ROM address 0x000.

Verification
REQ-033 Reset, then enable=1, rom_ready=1, rom_data=0xA5 then 0x3C, inc_pc=1 -> instr=0xA, oprnd=0x5, program_byte=0x3C, address_ram=0x53C, pc=0x002 after 2 cycles, retire pulse, instr_count=1.
REQ-034 FETCH byte 0x7F, EXEC rom_data=0xE2, load_pc=1, inc_pc=1 -> pc=0xFE2, phase=0, next fetch from 0xFE2.
REQ-035 pc=0xFFF in FETCH, advance -> pc=0x000, phase=1; an EXEC advance with inc_pc=1 then gives pc=0x001.
REQ-036 Drop rom_ready for 3 cycles in EXEC -> stall=1, pc/phase/instr/instr_count unchanged; retire=1 exactly once after release.
REQ-037 Assert reset during EXEC with load_pc=1 -> next cycle pc=0x000, phase=0, instr_count=0, no retire.
REQ-038 enable=0 for 5 cycles mid-FETCH -> no state change, stall=0; resumes identically when enable=1.
